// File: rtl/turbo_pkg.sv
// Shared types and constants for the TurboDecoder stream-to-bus packer.
// Header bit positions and N describe the default 512-bit bus build.
package turbo_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_HOLD
  } state_e;

  localparam int HDR_FIRST = 15;
  localparam int HDR_LAST  = 14;
  localparam int N         = 496 / 24;

endpackage

// File: rtl/st2bus.sv
// Packs ST-bit stream samples into BUS-bit words with a frame header.
// Optional ST2BUS_ERR_EN: sticky err on sop/framing protocol violations.
module st2bus
  import turbo_pkg::*;
#(
  parameter int BUS                  = 512,
  parameter int BUS_HEAD             = 16,
  parameter int BUS_PAYLOAD          = 496,
  parameter int ST                   = 24,
  parameter int w_NumOfBUS_in_AFUFrm = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ST-1:0]   st_data,
  input  logic            st_valid,
  input  logic            st_sop,
  input  logic            st_eop,
  output logic            st_ready,
  output logic [BUS-1:0]  bus_data,
  output logic            bus_en,
  input  logic            bus_ready,
  output logic            err
);

  localparam int NW = BUS_PAYLOAD / ST;
  localparam int CW = $clog2(NW + 1);
  localparam int IW = w_NumOfBUS_in_AFUFrm;

`ifdef ST2BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [BUS_PAYLOAD-1:0] pack_q, pack_d;
  logic [BUS_PAYLOAD-1:0] ins_pl, emit_pl;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic [BUS-1:0]         out_q, out_d;
  logic                   out_v_q, out_v_d;
  logic                   err_q, err_d;
  logic [BUS_HEAD-1:0]    hdr;
  logic                   acc, room, err_set;
  logic                   done, done_last, done_first;
  logic                   emit, emit_last, emit_first;

  assign st_ready = !rst && (state_q != S_HOLD);
  assign acc      = st_valid & st_ready;
  assign room     = !out_v_q | bus_ready;

  always_comb begin
    state_d    = state_q;
    pack_d     = pack_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    first_d    = first_q;
    last_d     = last_q;
    out_d      = out_q;
    out_v_d    = out_v_q & ~bus_ready;
    err_set    = 1'b0;
    done       = 1'b0;
    done_last  = 1'b0;
    done_first = first_q;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_first = 1'b0;
    emit_pl    = '0;
    hdr        = '0;

    ins_pl = pack_q;
    ins_pl[32'(cnt_q) * ST +: ST] = st_data;

    unique case (state_q)
      S_IDLE: begin
        if (acc && st_sop) begin
          done_first = 1'b1;
          if (st_eop) begin
            done      = 1'b1;
            done_last = 1'b1;
          end else begin
            first_d = 1'b1;
            pack_d  = ins_pl;
            cnt_d   = CW'(1);
            state_d = S_PACK;
          end
        end else if (acc) begin
          err_set = 1'b1;
        end
      end
      S_PACK: begin
        if (acc) begin
          err_set = st_sop;
          if (st_eop || cnt_q == CW'(NW - 1)) begin
            done      = 1'b1;
            done_last = st_eop;
          end else begin
            pack_d = ins_pl;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus_ready) begin
          emit       = 1'b1;
          emit_pl    = pack_q;
          emit_last  = last_q;
          emit_first = first_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completed word waits in the pack register if the output is stalled
    if (done && room) begin
      emit       = 1'b1;
      emit_pl    = ins_pl;
      emit_last  = done_last;
      emit_first = done_first;
    end else if (done) begin
      pack_d  = ins_pl;
      last_d  = done_last;
      first_d = done_first;
      state_d = S_HOLD;
    end

    hdr[HDR_FIRST] = emit_first;
    hdr[HDR_LAST]  = emit_last;
    hdr[IW-1:0]    = idx_q;

    if (emit) begin
      out_d   = {emit_pl, hdr};
      out_v_d = 1'b1;
      pack_d  = '0;
      cnt_d   = '0;
      first_d = 1'b0;
      last_d  = 1'b0;
      idx_d   = emit_last ? '0 : idx_q + 1'b1;
      state_d = emit_last ? S_IDLE : S_PACK;
    end

    err_d = err_q | (ERR_EN & err_set);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pack_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      err_q   <= err_d;
    end
  end

  assign bus_data = out_q;
  assign bus_en   = out_v_q;
  assign err      = err_q;

endmodule

// File: tb/tb_st2bus.sv
// Directed bench for st2bus: per-cycle vector table plus frame sequences.
// Expected err behaviour follows ST2BUS_ERR_EN.
module tb_st2bus;

  localparam int BUS = 512;
  localparam int HD  = 16;
  localparam int ST  = 24;
  localparam int NS  = 20;

`ifdef ST2BUS_ERR_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [ST-1:0]  st_data;
  logic           st_valid, st_sop, st_eop;
  logic           st_ready;
  logic [BUS-1:0] bus_data;
  logic           bus_en;
  logic           bus_ready;
  logic           err;

  st2bus dut (
    .clk       (clk),
    .rst       (rst),
    .st_data   (st_data),
    .st_valid  (st_valid),
    .st_sop    (st_sop),
    .st_eop    (st_eop),
    .st_ready  (st_ready),
    .bus_data  (bus_data),
    .bus_en    (bus_en),
    .bus_ready (bus_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, sop, eop;
    logic [23:0] d;
    logic        br;
    logic        e_rdy, e_en, e_err, chk_d;
    logic [15:0] e_hdr;
    logic [47:0] e_pl;
  } vec_t;

  vec_t vt[12];

  int checks = 0;
  int errors = 0;

  logic [15:0]    hq[$];
  logic [BUS-1:0] dq[$];
  logic           acc;
  logic           bmode = 1'b0;
  logic           en_seen;
  int             since;
  logic           rdy_drop;
  int             stab_err;
  logic           prev_stall;
  logic [BUS-1:0] prev_data;

  function automatic vec_t mk(logic v, logic sop, logic eop,
                              logic [23:0] d, logic br,
                              logic e_rdy, logic e_en, logic e_err,
                              logic chk_d, logic [15:0] e_hdr,
                              logic [47:0] e_pl);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.d = d; r.br = br;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_err = e_err;
    r.chk_d = chk_d; r.e_hdr = e_hdr; r.e_pl = e_pl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    if (bmode) begin
      if (bus_en) en_seen = 1'b1;
      if (en_seen) since++;
      bus_ready = (since > 30);
    end
    #1;
    if (!st_ready) rdy_drop = 1'b1;
    if (prev_stall && !(bus_en && bus_data == prev_data)) stab_err++;
    prev_stall = bus_en && !bus_ready;
    prev_data  = bus_data;
    if (bus_en && bus_ready) begin
      hq.push_back(bus_data[15:0]);
      dq.push_back(bus_data);
    end
    acc = st_valid && st_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    repeat (n) tick();
  endtask

  task automatic feed(input int base, input int n,
                      input bit sop_en, input bit eop_en);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      st_valid = 1'b1;
      st_data  = 24'(base + i);
      st_sop   = sop_en && (i == 0);
      st_eop   = eop_en && (i == n - 1);
      tick();
      if (acc) i++;
      guard++;
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    if (i < n) chk("feed_timeout", 64'(i), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hq.delete();
    dq.delete();
    prev_stall = 1'b0;
    rdy_drop = 1'b0;
    stab_err = 0;
  endtask

  task automatic chk_stream(input string nm, input int base,
                            input int total);
    int bad = 0;
    int nw = (total + NS - 1) / NS;
    int cnt;
    logic [BUS-1:0] w;
    chk({nm, "_words"}, 64'(dq.size()), 64'(nw));
    for (int i = 0; i < dq.size() && i < nw; i++) begin
      w = dq[i];
      cnt = (total - i * NS > NS) ? NS : total - i * NS;
      for (int k = 0; k < cnt; k++)
        if (w[HD + k * ST +: ST] != 24'(base + i * NS + k)) bad++;
    end
    chk({nm, "_samples"}, 64'(bad), 64'(0));
  endtask

  initial begin
    logic [BUS-1:0] w;
    rst = 1'b1;
    st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    bus_ready = 1'b1;
    prev_stall = 1'b0; prev_data = '0;
    rdy_drop = 1'b0; stab_err = 0; en_seen = 1'b0; since = 0;
    acc = 1'b0;

    vt[0]  = mk(0,0,0,24'h0,     1, 1,0,0, 0,16'h0,    48'h0);
    vt[1]  = mk(1,1,1,24'hABCDEF,1, 1,0,0, 0,16'h0,    48'h0);
    vt[2]  = mk(0,0,0,24'h0,     1, 1,1,0, 1,16'hC000, 48'hABCDEF);
    vt[3]  = mk(1,1,0,24'h11,    1, 1,0,0, 0,16'h0,    48'h0);
    vt[4]  = mk(1,0,1,24'h22,    1, 1,0,0, 0,16'h0,    48'h0);
    vt[5]  = mk(0,0,0,24'h0,     0, 1,1,0, 1,16'hC000, 48'h000022000011);
    vt[6]  = mk(1,1,1,24'h33,    0, 1,1,0, 1,16'hC000, 48'h000022000011);
    vt[7]  = mk(0,0,0,24'h0,     0, 0,1,0, 1,16'hC000, 48'h000022000011);
    vt[8]  = mk(0,0,0,24'h0,     1, 0,1,0, 1,16'hC000, 48'h000022000011);
    vt[9]  = mk(0,0,0,24'h0,     1, 1,1,0, 1,16'hC000, 48'h000000000033);
    vt[10] = mk(1,0,0,24'h99,    1, 1,0,0, 0,16'h0,    48'h0);
    vt[11] = mk(0,0,0,24'h0,     1, 1,0,EXP_ERR, 0,16'h0, 48'h0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdy", 64'(st_ready), 64'(0));
    chk("rst_en", 64'(bus_en), 64'(0));
    chk("rst_data", 64'(bus_data == '0), 64'(1));
    chk("rst_err", 64'(err), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      st_valid = vt[i].v; st_sop = vt[i].sop; st_eop = vt[i].eop;
      st_data = vt[i].d; bus_ready = vt[i].br;
      #1;
      chk($sformatf("v%0d_rdy", i), 64'(st_ready), 64'(vt[i].e_rdy));
      chk($sformatf("v%0d_en", i), 64'(bus_en), 64'(vt[i].e_en));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].e_err));
      if (vt[i].chk_d) begin
        chk($sformatf("v%0d_hdr", i), 64'(bus_data[15:0]), 64'(vt[i].e_hdr));
        chk($sformatf("v%0d_pl", i), 64'(bus_data[63:16]), 64'(vt[i].e_pl));
        chk($sformatf("v%0d_plhi", i), 64'(bus_data[BUS-1:64] == '0), 64'(1));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // 45-sample frame, bus always ready
    do_reset();
    bus_ready = 1'b1;
    feed(1, 45, 1, 1);
    idle(5);
    chk_stream("f45", 1, 45);
    if (hq.size() == 3) begin
      chk("f45_h0", 64'(hq[0]), 64'h8000);
      chk("f45_h1", 64'(hq[1]), 64'h0001);
      chk("f45_h2", 64'(hq[2]), 64'h4002);
      w = dq[2];
      chk("f45_w3_hi", 64'(w[BUS-1:HD+120] == '0), 64'(1));
    end
    chk("f45_no_stall", 64'(rdy_drop), 64'(0));

    // 60-sample frame with a 30-cycle output stall
    do_reset();
    en_seen = 1'b0; since = 0;
    bmode = 1'b1;
    feed(1, 60, 1, 1);
    idle(40);
    bmode = 1'b0;
    bus_ready = 1'b1;
    chk("f60_rdy_drop", 64'(rdy_drop), 64'(1));
    chk("f60_stable", 64'(stab_err), 64'(0));
    chk_stream("f60", 1, 60);
    if (hq.size() == 3) begin
      chk("f60_h0", 64'(hq[0]), 64'h8000);
      chk("f60_h2", 64'(hq[2]), 64'h4002);
    end

    // Reset in the middle of a frame
    do_reset();
    bus_ready = 1'b1;
    feed(100, 10, 1, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(st_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(st_ready), 64'(1));
    @(negedge clk);
    idle(3);
    chk("mid_rst_words", 64'(dq.size()), 64'(0));
    feed(200, 3, 1, 1);
    idle(3);
    chk("after_rst_words", 64'(dq.size()), 64'(1));
    if (dq.size() == 1) begin
      chk("after_rst_hdr", 64'(hq[0]), 64'hC000);
      w = dq[0];
      chk("after_rst_s0", 64'(w[HD +: ST]), 64'(200));
    end

    // Samples without sop while idle
    do_reset();
    #1;
    chk("nosop_err0", 64'(err), 64'(0));
    @(negedge clk);
    feed(300, 3, 0, 0);
    idle(3);
    chk("nosop_err", 64'(err), 64'(EXP_ERR));
    chk("nosop_words", 64'(dq.size()), 64'(0));
    do_reset();
    #1;
    chk("err_clr", 64'(err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
